// File: rtl/decode_queue_nway_if.sv
// Shared decode types plus the fetch/issue-side bundle of the N-way decode queue.
// The package sits with the interface so that both the design and its users see one element layout.
package decode_queue_nway_pkg;

    typedef enum logic [2:0] {
        EXE_ARITHMATIC = 3'd0,
        EXE_LOGIC      = 3'd1,
        EXE_SHIFT      = 3'd2,
        EXE_MUL        = 3'd3,
        EXE_JUMP       = 3'd4,
        EXE_BRANCH     = 3'd5,
        EXE_MEM        = 3'd6
    } exe_type_t;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_OR  = 3'd2,
        ALU_LUI = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_MUL = 3'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        BC_NBC  = 2'd0,
        BC_NE   = 2'd1,
        BC_JUMP = 2'd2,
        BC_JR   = 2'd3
    } branch_t;

    // imm carries the ALU immediate, shift amount or jump index; offset the mem/branch displacement
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] predict_pc_addr;
        logic        predict_brunch_taken;
        exe_type_t   exe_type;
        alu_op_t     alu_op;
        branch_t     branch_type;
        logic        read_reg1_need;
        logic [4:0]  read_reg1_addr;
        logic        read_reg2_need;
        logic [4:0]  read_reg2_addr;
        logic        write_reg_need;
        logic [4:0]  write_reg_addr;
        logic [31:0] imm;
        logic [31:0] offset;
        logic        mem_read_ena;
        logic        mem_write_ena;
    } iq_elem_t;

    localparam iq_elem_t IQ_NOP = '0;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_MUL  = 6'h02;

endpackage

interface decode_queue_nway_if #(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8
);
    import decode_queue_nway_pkg::*;

    logic                             flush;
    logic [IN_WIDTH-1:0]              in_valid;
    logic [32*IN_WIDTH-1:0]           in_inst;
    logic [32*IN_WIDTH-1:0]           in_pc;
    logic [32*IN_WIDTH-1:0]           in_pred_pc;
    logic [IN_WIDTH-1:0]              in_pred_taken;
    logic                             in_ready;
    logic [OUT_WIDTH-1:0]             out_valid;
    iq_elem_t [OUT_WIDTH-1:0]         out_elem;
    logic [OUT_WIDTH-1:0]             out_ri;
    logic [$clog2(OUT_WIDTH+1)-1:0]   out_take;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output flush, in_valid, in_inst, in_pc, in_pred_pc, in_pred_taken, out_take,
        input  in_ready, out_valid, out_elem, out_ri, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_pred_pc, in_pred_taken, out_take,
        output in_ready, out_valid, out_elem, out_ri, count
    );

endinterface

// File: rtl/decode_queue_nway.sv
// Multi-lane decode queue: accepts up to IN_WIDTH fetched words per cycle into a circular
// buffer and presents the OUT_WIDTH oldest entries decoded into issue-queue elements.
module decode_queue_nway
    import decode_queue_nway_pkg::*;
#(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int DEPTH     = 8
) (
    input  logic               clk,
    input  logic               rst,
    decode_queue_nway_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        pred_taken;
    } entry_t;

    typedef struct packed {
        logic     ri;
        iq_elem_t elem;
    } dec_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] n_take;
    logic             in_ready;
    logic             enq_fire;
    logic [PTR_W-1:0] wr_idx [IN_WIDTH];
    logic [PTR_W-1:0] rd_idx [OUT_WIDTH];

    function automatic dec_t decode_lane(input entry_t e);
        dec_t        d;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] i16;
        logic [31:0] sext;
        op   = e.inst[31:26];
        fn   = e.inst[5:0];
        rs   = e.inst[25:21];
        rt   = e.inst[20:16];
        rd   = e.inst[15:11];
        sa   = e.inst[10:6];
        i16  = e.inst[15:0];
        sext = {{16{i16[15]}}, i16};
        d = '0;
        d.elem.pc                   = e.pc;
        d.elem.predict_pc_addr      = e.pred_pc;
        d.elem.predict_brunch_taken = e.pred_taken;
        case (op)
            OP_ORI: begin
                d.elem.exe_type       = EXE_LOGIC;
                d.elem.alu_op         = ALU_OR;
                d.elem.read_reg1_need = 1'b1;
                d.elem.read_reg1_addr = rs;
                d.elem.write_reg_need = 1'b1;
                d.elem.write_reg_addr = rt;
                d.elem.imm            = {16'h0000, i16};
            end
            OP_LUI: begin
                d.elem.exe_type       = EXE_ARITHMATIC;
                d.elem.alu_op         = ALU_LUI;
                d.elem.write_reg_need = 1'b1;
                d.elem.write_reg_addr = rt;
                d.elem.imm            = {i16, 16'h0000};
            end
            OP_ADDIU: begin
                d.elem.exe_type       = EXE_ARITHMATIC;
                d.elem.alu_op         = ALU_ADD;
                d.elem.read_reg1_need = 1'b1;
                d.elem.read_reg1_addr = rs;
                d.elem.write_reg_need = 1'b1;
                d.elem.write_reg_addr = rt;
                d.elem.imm            = sext;
            end
            OP_J, OP_JAL: begin
                d.elem.exe_type    = EXE_JUMP;
                d.elem.branch_type = BC_JUMP;
                d.elem.imm         = {6'b0, e.inst[25:0]};
                if (op == OP_JAL) begin
                    d.elem.write_reg_need = 1'b1;
                    d.elem.write_reg_addr = 5'd31;
                end
            end
            OP_BNE: begin
                d.elem.exe_type       = EXE_BRANCH;
                d.elem.branch_type    = BC_NE;
                d.elem.read_reg1_need = 1'b1;
                d.elem.read_reg1_addr = rs;
                d.elem.read_reg2_need = 1'b1;
                d.elem.read_reg2_addr = rt;
                d.elem.offset         = {sext[29:0], 2'b00};
            end
            OP_LW, OP_SW: begin
                d.elem.exe_type       = EXE_MEM;
                d.elem.alu_op         = ALU_ADD;
                d.elem.read_reg1_need = 1'b1;
                d.elem.read_reg1_addr = rs;
                d.elem.offset         = sext;
                if (op == OP_LW) begin
                    d.elem.mem_read_ena   = 1'b1;
                    d.elem.write_reg_need = 1'b1;
                    d.elem.write_reg_addr = rt;
                end else begin
                    d.elem.mem_write_ena  = 1'b1;
                    d.elem.read_reg2_need = 1'b1;
                    d.elem.read_reg2_addr = rt;
                end
            end
            OP_SPECIAL: begin
                case (fn)
                    FN_JR: begin
                        d.elem.exe_type       = EXE_JUMP;
                        d.elem.branch_type    = BC_JR;
                        d.elem.read_reg1_need = 1'b1;
                        d.elem.read_reg1_addr = rs;
                    end
                    FN_ADDU: begin
                        d.elem.exe_type       = EXE_ARITHMATIC;
                        d.elem.alu_op         = ALU_ADD;
                        d.elem.read_reg1_need = 1'b1;
                        d.elem.read_reg1_addr = rs;
                        d.elem.read_reg2_need = 1'b1;
                        d.elem.read_reg2_addr = rt;
                        d.elem.write_reg_need = 1'b1;
                        d.elem.write_reg_addr = rd;
                    end
                    FN_SLL, FN_SRL: begin
                        d.elem.exe_type       = EXE_SHIFT;
                        d.elem.alu_op         = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
                        d.elem.read_reg2_need = 1'b1;
                        d.elem.read_reg2_addr = rt;
                        d.elem.write_reg_need = 1'b1;
                        d.elem.write_reg_addr = rd;
                        d.elem.imm            = {27'b0, sa};
                    end
                    default: d.ri = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                if (fn == FN_MUL) begin
                    d.elem.exe_type       = EXE_MUL;
                    d.elem.alu_op         = ALU_MUL;
                    d.elem.read_reg1_need = 1'b1;
                    d.elem.read_reg1_addr = rs;
                    d.elem.read_reg2_need = 1'b1;
                    d.elem.read_reg2_addr = rt;
                    d.elem.write_reg_need = 1'b1;
                    d.elem.write_reg_addr = rd;
                end else begin
                    d.ri = 1'b1;
                end
            end
            default: d.ri = 1'b1;
        endcase
        return d;
    endfunction

    // in_ready looks only at registered occupancy so out_take never reaches it combinationally
    always_comb begin
        in_ready = (count_q <= CNT_W'(DEPTH - IN_WIDTH));
        n_in     = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            n_in = n_in + CNT_W'(bus.in_valid[i]);
        end
        n_take   = (CNT_W'(bus.out_take) > count_q) ? count_q : CNT_W'(bus.out_take);
        enq_fire = in_ready && bus.in_valid[0] && !bus.flush;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_idx[i] = tail_q + PTR_W'(i);
        end
        for (int k = 0; k < OUT_WIDTH; k++) begin
            rd_idx[k] = head_q + PTR_W'(k);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(n_take);
            tail_d  = enq_fire ? tail_q + PTR_W'(n_in) : tail_q;
            count_d = count_q + (enq_fire ? n_in : '0) - n_take;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset: pointers and count alone define which slots are live
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (enq_fire && bus.in_valid[i]) begin
                mem_q[wr_idx[i]] <= '{inst:       bus.in_inst[32*i +: 32],
                                      pc:         bus.in_pc[32*i +: 32],
                                      pred_pc:    bus.in_pred_pc[32*i +: 32],
                                      pred_taken: bus.in_pred_taken[i]};
            end
        end
    end

    always_comb begin
        bus.in_ready  = in_ready;
        bus.count     = count_q;
        bus.out_valid = '0;
        bus.out_ri    = '0;
        bus.out_elem  = {OUT_WIDTH{IQ_NOP}};
        for (int k = 0; k < OUT_WIDTH; k++) begin
            if (count_q > CNT_W'(k)) begin
                bus.out_valid[k] = 1'b1;
                bus.out_elem[k]  = decode_lane(mem_q[rd_idx[k]]).elem;
                bus.out_ri[k]    = decode_lane(mem_q[rd_idx[k]]).ri;
            end
        end
    end

    // Taking more than is presented is an issue-queue protocol error; the clamp above keeps state sane
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            assert (CNT_W'(bus.out_take) <= count_q && int'(bus.out_take) <= OUT_WIDTH);
        end
    end

endmodule

// File: tb/tb_decode_queue_nway.sv
// Bench for decode_queue_nway: directed traffic, a queue-based reference model checked every cycle,
// and literal expectations for reset, fill, wrap, decode, flush and prediction passthrough.
module tb_decode_queue_nway;
    import decode_queue_nway_pkg::*;

    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int DEPTH = 8;
    localparam logic [31:0] PC0 = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_queue_nway_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH)) bus ();
    decode_queue_nway #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        tk;
    } ment_t;

    typedef enum {M_RI, M_ORI, M_LUI, M_ADDIU, M_J, M_JAL, M_BNE, M_LW, M_SW,
                  M_JR, M_ADDU, M_SLL, M_SRL, M_MUL} mn_t;

    ment_t mq[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic mn_t classify(input logic [31:0] w);
        case (w[31:26])
            6'h0D: return M_ORI;
            6'h0F: return M_LUI;
            6'h09: return M_ADDIU;
            6'h02: return M_J;
            6'h03: return M_JAL;
            6'h05: return M_BNE;
            6'h23: return M_LW;
            6'h2B: return M_SW;
            6'h1C: return (w[5:0] == 6'h02) ? M_MUL : M_RI;
            6'h00: begin
                case (w[5:0])
                    6'h00:   return M_SLL;
                    6'h02:   return M_SRL;
                    6'h08:   return M_JR;
                    6'h21:   return M_ADDU;
                    default: return M_RI;
                endcase
            end
            default: return M_RI;
        endcase
    endfunction

    // Builds the expected element column by column: which operands, which unit, which immediate
    function automatic void ref_decode(input ment_t m, output iq_elem_t e, output logic ri);
        mn_t         c;
        logic [31:0] w;
        logic [31:0] sx;
        w  = m.inst;
        c  = classify(w);
        sx = {{16{w[15]}}, w[15:0]};
        e  = '0;
        e.pc                   = m.pc;
        e.predict_pc_addr      = m.pred;
        e.predict_brunch_taken = m.tk;
        ri = (c == M_RI);
        if (c inside {M_ORI, M_ADDIU, M_LW, M_SW, M_BNE, M_JR, M_ADDU, M_MUL}) begin
            e.read_reg1_need = 1'b1;
            e.read_reg1_addr = w[25:21];
        end
        if (c inside {M_BNE, M_SW, M_ADDU, M_MUL, M_SLL, M_SRL}) begin
            e.read_reg2_need = 1'b1;
            e.read_reg2_addr = w[20:16];
        end
        if (c inside {M_ORI, M_LUI, M_ADDIU, M_LW}) begin
            e.write_reg_need = 1'b1;
            e.write_reg_addr = w[20:16];
        end
        if (c inside {M_ADDU, M_SLL, M_SRL, M_MUL}) begin
            e.write_reg_need = 1'b1;
            e.write_reg_addr = w[15:11];
        end
        if (c == M_JAL) begin
            e.write_reg_need = 1'b1;
            e.write_reg_addr = 5'd31;
        end
        case (c)
            M_ORI:                e.exe_type = EXE_LOGIC;
            M_SLL, M_SRL:         e.exe_type = EXE_SHIFT;
            M_MUL:                e.exe_type = EXE_MUL;
            M_J, M_JAL, M_JR:     e.exe_type = EXE_JUMP;
            M_BNE:                e.exe_type = EXE_BRANCH;
            M_LW, M_SW:           e.exe_type = EXE_MEM;
            default:              e.exe_type = EXE_ARITHMATIC;
        endcase
        case (c)
            M_ADDIU, M_ADDU, M_LW, M_SW: e.alu_op = ALU_ADD;
            M_ORI:                       e.alu_op = ALU_OR;
            M_LUI:                       e.alu_op = ALU_LUI;
            M_SLL:                       e.alu_op = ALU_SLL;
            M_SRL:                       e.alu_op = ALU_SRL;
            M_MUL:                       e.alu_op = ALU_MUL;
            default:                     e.alu_op = ALU_NOP;
        endcase
        case (c)
            M_BNE:      e.branch_type = BC_NE;
            M_J, M_JAL: e.branch_type = BC_JUMP;
            M_JR:       e.branch_type = BC_JR;
            default:    e.branch_type = BC_NBC;
        endcase
        case (c)
            M_ORI:        e.imm = {16'h0, w[15:0]};
            M_LUI:        e.imm = {w[15:0], 16'h0};
            M_ADDIU:      e.imm = sx;
            M_J, M_JAL:   e.imm = {6'b0, w[25:0]};
            M_SLL, M_SRL: e.imm = {27'b0, w[10:6]};
            default:      e.imm = 32'h0;
        endcase
        if (c inside {M_LW, M_SW}) e.offset = sx;
        if (c == M_BNE)            e.offset = sx * 4;
        e.mem_read_ena  = (c == M_LW);
        e.mem_write_ena = (c == M_SW);
    endfunction

    // Reference queue advances on every edge from the inputs the DUT also sees
    always @(posedge clk) begin : model
        int take;
        bit rdy;
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            take = int'(bus.out_take);
            if (take > mq.size()) take = mq.size();
            rdy = (DEPTH - mq.size()) >= IN_W;
            repeat (take) void'(mq.pop_front());
            if (rdy && bus.in_valid[0]) begin
                for (int i = 0; i < IN_W; i++) begin
                    if (bus.in_valid[i]) begin
                        mq.push_back('{inst: bus.in_inst[32*i +: 32], pc: bus.in_pc[32*i +: 32],
                                       pred: bus.in_pred_pc[32*i +: 32], tk: bus.in_pred_taken[i]});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int             sz;
        logic [OUT_W-1:0] ev;
        iq_elem_t       ee;
        logic           er;
        if (chk_en) begin
            sz = mq.size();
            chk("count", 160'(bus.count), 160'(sz));
            chk("in_ready", 160'(bus.in_ready), 160'((DEPTH - sz) >= IN_W));
            for (int k = 0; k < OUT_W; k++) ev[k] = (sz > k);
            chk("out_valid", 160'(bus.out_valid), 160'(ev));
            for (int k = 0; k < OUT_W; k++) begin
                if (k < sz) begin
                    ref_decode(mq[k], ee, er);
                    chk($sformatf("out_elem[%0d]", k), 160'(bus.out_elem[k]), 160'(ee));
                    chk($sformatf("out_ri[%0d]", k), 160'(bus.out_ri[k]), 160'(er));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] pc0);
        bus.in_valid      = v;
        bus.in_inst       = {i1, i0};
        bus.in_pc         = {pc0 + 32'd4, pc0};
        bus.in_pred_pc    = {pc0 + 32'd8, pc0 + 32'd4};
        bus.in_pred_taken = 2'b00;
    endtask

    task automatic idle();
        bus.in_valid = 2'b00;
    endtask

    logic [31:0] dec_a [7];
    logic [31:0] dec_b [7];

    initial begin
        rst               = 1'b1;
        bus.flush         = 1'b0;
        bus.out_take      = '0;
        bus.in_valid      = '0;
        bus.in_inst       = '0;
        bus.in_pc         = '0;
        bus.in_pred_pc    = '0;
        bus.in_pred_taken = '0;
        dec_a = '{32'h342200FF, 32'h08100000, 32'h1422FFFC, 32'h03E00008,
                  32'h00023100, 32'h70224002, 32'h0000003F};
        dec_b = '{32'h3C041234, 32'h0C000040, 32'hAFA30008, 32'h00222821,
                  32'h000238C2, 32'h00000000, 32'h7000003F};

        // Reset for two edges
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst count", 160'(bus.count), 160'(0));
        chk("rst in_ready", 160'(bus.in_ready), 160'(1));
        chk("rst out_valid", 160'(bus.out_valid), 160'(0));

        // Fill to full with ADDIU r1,r0,imm; the fifth group must be held off
        for (int g = 0; g < 4; g++) begin
            set_in(2'b11, 32'h24010005 + 32'(2*g), 32'h24010006 + 32'(2*g), PC0 + 32'(8*g));
            step();
        end
        chk("fill count", 160'(bus.count), 160'(8));
        chk("fill in_ready", 160'(bus.in_ready), 160'(0));
        chk("fill lane0 imm", 160'(bus.out_elem[0].imm), 160'(32'h5));
        set_in(2'b11, 32'h2401000D, 32'h2401000E, PC0 + 32'h20);
        step();
        chk("held count", 160'(bus.count), 160'(8));

        // Drain two per cycle across the wrap while refilling once there is room
        idle();
        bus.out_take = 2'd2;
        step();
        chk("drain1 lane0 pc", 160'(bus.out_elem[0].pc), 160'(PC0 + 32'h8));
        for (int g = 4; g < 7; g++) begin
            set_in(2'b11, 32'h24010005 + 32'(2*g), 32'h24010006 + 32'(2*g), PC0 + 32'(8*g));
            step();
        end
        idle();
        chk("wrap count", 160'(bus.count), 160'(6));
        chk("wrap lane0 pc", 160'(bus.out_elem[0].pc), 160'(PC0 + 32'h20));
        repeat (3) step();
        chk("drained count", 160'(bus.count), 160'(0));

        // Decode: LW plus a reserved opcode, then every supported form
        bus.out_take = 2'd0;
        set_in(2'b11, 32'h8C430010, 32'hFC000000, PC0 + 32'h100);
        step();
        idle();
        chk("lw mem_read_ena", 160'(bus.out_elem[0].mem_read_ena), 160'(1));
        chk("lw offset", 160'(bus.out_elem[0].offset), 160'(32'h10));
        chk("lw write_reg_addr", 160'(bus.out_elem[0].write_reg_addr), 160'(3));
        chk("lw ri", 160'(bus.out_ri[0]), 160'(0));
        chk("rsv ri", 160'(bus.out_ri[1]), 160'(1));
        chk("rsv write_reg_need", 160'(bus.out_elem[1].write_reg_need), 160'(0));
        bus.out_take = 2'd2;
        for (int g = 0; g < 7; g++) begin
            set_in(2'b11, dec_a[g], dec_b[g], PC0 + 32'h110 + 32'(8*g));
            step();
            if (g == 5) begin
                chk("zero word ri", 160'(bus.out_ri[1]), 160'(0));
                chk("zero word alu", 160'(bus.out_elem[1].alu_op), 160'(ALU_SLL));
            end
        end
        idle();
        chk("bad funct ri", 160'(bus.out_ri), 160'(2'b11));
        step();

        // Flush at occupancy 5 with a simultaneous enqueue
        bus.out_take = 2'd0;
        set_in(2'b11, 32'h24010001, 32'h24010002, PC0 + 32'h300);
        step();
        set_in(2'b11, 32'h24010003, 32'h24010004, PC0 + 32'h308);
        step();
        set_in(2'b01, 32'h24010005, 32'h24010006, PC0 + 32'h310);
        step();
        chk("preflush count", 160'(bus.count), 160'(5));
        set_in(2'b11, 32'h24010007, 32'h24010008, PC0 + 32'h318);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        chk("flush count", 160'(bus.count), 160'(0));
        chk("flush out_valid", 160'(bus.out_valid), 160'(0));
        chk("flush tail", 160'(dut.tail_q), 160'(0));
        set_in(2'b11, 32'h24010009, 32'h2401000A, PC0 + 32'h200);
        step();
        idle();
        chk("post-flush pc", 160'(bus.out_elem[0].pc), 160'(PC0 + 32'h200));
        chk("post-flush tail", 160'(dut.tail_q), 160'(2));
        bus.out_take = 2'd2;
        step();

        // Prediction passthrough on a JAL
        bus.out_take          = 2'd0;
        bus.in_valid          = 2'b01;
        bus.in_inst[31:0]     = 32'h0FF00040;
        bus.in_pc[31:0]       = 32'hBFC00010;
        bus.in_pred_pc[31:0]  = 32'hBFC00100;
        bus.in_pred_taken     = 2'b01;
        step();
        idle();
        chk("jal pc", 160'(bus.out_elem[0].pc), 160'(32'hBFC00010));
        chk("jal pred pc", 160'(bus.out_elem[0].predict_pc_addr), 160'(32'hBFC00100));
        chk("jal pred taken", 160'(bus.out_elem[0].predict_brunch_taken), 160'(1));
        chk("jal write_reg_addr", 160'(bus.out_elem[0].write_reg_addr), 160'(31));
        chk("jal ri", 160'(bus.out_ri[0]), 160'(0));

        // Reset wins over flush and traffic
        set_in(2'b11, 32'h24010001, 32'h24010002, PC0 + 32'h400);
        step();
        rst          = 1'b1;
        bus.flush    = 1'b1;
        bus.out_take = 2'd1;
        step();
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.out_take = 2'd0;
        idle();
        chk("rst-override count", 160'(bus.count), 160'(0));
        chk("rst-override ready", 160'(bus.in_ready), 160'(1));
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
